// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types and constants used by the fetch stage.
// The packed fetch entry pairs each instruction word with the PC it came from.
package riscv_pkg;

  localparam int INSTR_W = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Word-align an address by clearing its two low bits.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle for the fetch stage: instruction-memory request/response,
// decode-side valid/ready, and the redirect input from the branch unit.
interface fetch_unit_if;
  import riscv_pkg::*;

  logic               oImem_req;
  logic [31:0]        oImem_addr;
  logic               iImem_gnt;
  logic               iImem_rvalid;
  logic [INSTR_W-1:0] iImem_rdata;

  logic               oInstr_valid;
  logic [INSTR_W-1:0] oInstruction;
  logic [31:0]        oPc;
  logic               iInstr_ready;

  logic               iRedirect;
  logic [31:0]        iRedirect_pc;

  modport master (
    output oImem_req, oImem_addr, oInstr_valid, oInstruction, oPc,
    input  iImem_gnt, iImem_rvalid, iImem_rdata, iInstr_ready,
    input  iRedirect, iRedirect_pc
  );

  modport slave (
    input  oImem_req, oImem_addr, oInstr_valid, oInstruction, oPc,
    output iImem_gnt, iImem_rvalid, iImem_rdata, iInstr_ready,
    output iRedirect, iRedirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush; used both as the
// instruction buffer and as the tracker of PCs for outstanding requests.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           flush,
  input  fetch_entry_t                   din,
  output fetch_entry_t                   head,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A push into a full FIFO is only allowed when the head leaves in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited requests to instruction memory,
// in-order response pairing with issued PCs, and redirect flush/drop handling.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic          iClk,
  input  logic          iRst,
  fetch_unit_if.master  bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(DEPTH);

  logic [31:0]   pc_q;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] inflight_next;
  logic [CW-1:0] drop_q;
  logic [CW:0]   credit_used;

  logic          imem_req;
  logic          grant;
  logic          resp;
  logic          keep;
  logic          redirect;
  logic          out_valid;
  logic          buf_pop;
  logic          buf_push;

  fetch_entry_t  buf_head;
  fetch_entry_t  trk_head;
  fetch_entry_t  trk_din;
  fetch_entry_t  push_entry;

  // Buffered words plus outstanding requests may never exceed the buffer size,
  // so every response always has a slot waiting for it.
  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
  assign imem_req    = !iRst && (credit_used < CREDIT_MAX);
  assign grant       = imem_req && bus.iImem_gnt;
  assign resp        = bus.iImem_rvalid && (inflight != '0);
  assign keep        = resp && (drop_q == '0);
  assign redirect    = bus.iRedirect;

  assign inflight_next = inflight + CW'(grant) - CW'(resp);

  assign out_valid = !iRst && (fifo_count != '0);
  assign buf_pop   = out_valid && bus.iInstr_ready && !redirect;
  assign buf_push  = keep && !redirect;

  assign trk_din = '{pc: pc_q, instr: '0};

  // Each kept response takes its PC from the tracker head.
  always_comb begin
    push_entry       = trk_head;
    push_entry.instr = bus.iImem_rdata;
  end

  // Tracker count doubles as the in-flight counter; it is never flushed so that
  // dropped responses still pop their PC and keep the pairing aligned.
  fetch_fifo #(.DEPTH(DEPTH)) u_tracker (
    .clk   (iClk),
    .rst   (iRst),
    .push  (grant),
    .pop   (resp),
    .flush (1'b0),
    .din   (trk_din),
    .head  (trk_head),
    .count (inflight)
  );

  fetch_fifo #(.DEPTH(DEPTH)) u_buffer (
    .clk   (iClk),
    .rst   (iRst),
    .push  (buf_push),
    .pop   (buf_pop),
    .flush (redirect),
    .din   (push_entry),
    .head  (buf_head),
    .count (fifo_count)
  );

  // Redirect wins over sequential advance; every request outstanding after this
  // cycle, including one granted now at the old PC, belongs to the dead path.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else if (redirect) begin
      pc_q   <= align_pc(bus.iRedirect_pc);
      drop_q <= inflight_next;
    end else begin
      if (grant) begin
        pc_q <= pc_q + 32'd4;
      end
      if (resp && (drop_q != '0)) begin
        drop_q <= drop_q - 1'b1;
      end
    end
  end

  assign bus.oImem_req    = imem_req;
  assign bus.oImem_addr   = pc_q;
  assign bus.oInstr_valid = out_valid;
  assign bus.oInstruction = out_valid ? buf_head.instr : '0;
  assign bus.oPc          = out_valid ? buf_head.pc    : '0;

endmodule
